// File: rtl/tpu_nn_accel.sv
// Single-layer NN accelerator: a controller FSM sequences a shared address counter
// through DEPTH multiply-accumulate steps for NEURONS parallel neurons, then ReLU.
module tpu_nn_mem #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2,
  parameter int AW    = 1
) (
  input  logic [AW-1:0]    addr,
  output logic [WIDTH-1:0] rdata
);
  // Contents are loaded from outside the design; the RTL only reads them.
  logic [WIDTH-1:0] memory [DEPTH] = '{default: '0};

  assign rdata = memory[addr];
endmodule

module tpu_nn_layer #(
  parameter int NEURONS = 2,
  parameter int DEPTH   = 2,
  parameter int WIDTH   = 64,
  parameter int AW      = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          mac_en,
  input  logic          act_en,
  input  logic [AW-1:0] addr
);
  logic [WIDTH-1:0] x;

  tpu_nn_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) MM (
    .addr  (addr),
    .rdata (x)
  );

  for (genvar n = 0; n < NEURONS; n++) begin : genblk1
    logic [WIDTH-1:0] w;
    logic [WIDTH-1:0] prod;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] out;
    logic             unused_out;

    tpu_nn_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) MM (
      .addr  (addr),
      .rdata (w)
    );

    // Low WIDTH bits of a two's-complement product match the unsigned product.
    assign prod = x * w;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        acc <= '0;
        out <= '0;
      end else begin
        if (clr)
          acc <= '0;
        else if (mac_en)
          acc <= acc + prod;
        if (act_en)
          out <= acc[WIDTH-1] ? '0 : acc;
      end
    end

    // Results are observed hierarchically, not through ports.
    assign unused_out = ^out;
  end
endmodule

module tpu_nn_ctrl #(
  parameter int NEURONS = 2,
  parameter int DEPTH   = 2,
  parameter int WIDTH   = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic ready
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    INIT = 3'd1,
    MAC  = 3'd2,
    ACT  = 3'd3,
    HOLD = 3'd4
  } state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] addr;
  logic          clr, mac_en, act_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = INIT;
      INIT:    state_nxt = MAC;
      MAC:     if (addr == LAST) state_nxt = ACT;
      ACT:     state_nxt = start ? HOLD : IDLE;
      HOLD:    if (!start) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ready  = (state == IDLE);
    clr    = (state == INIT);
    mac_en = (state == MAC);
    act_en = (state == ACT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      addr <= '0;
    else if (clr)
      addr <= '0;
    else if (mac_en)
      addr <= (addr == LAST) ? '0 : addr + 1'b1;
  end

  tpu_nn_layer #(.NEURONS(NEURONS), .DEPTH(DEPTH), .WIDTH(WIDTH), .AW(AW)) layer1 (
    .clk    (clk),
    .rst    (rst),
    .clr    (clr),
    .mac_en (mac_en),
    .act_en (act_en),
    .addr   (addr)
  );
endmodule

module tpu_nn_accel #(
  parameter int NEURONS = 2,
  parameter int DEPTH   = 2,
  parameter int WIDTH   = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic ready
);
  tpu_nn_ctrl #(.NEURONS(NEURONS), .DEPTH(DEPTH), .WIDTH(WIDTH)) datapath (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .ready (ready)
  );
endmodule

// File: tb/tb_tpu_nn_accel.sv
// Directed bench for tpu_nn_accel: preloads memories hierarchically, runs passes,
// checks busy length, ReLU results and reset behaviour against hand-computed values.
module tb_tpu_nn_accel;
  logic clk;
  logic rst;
  logic start;
  logic ready;

  int n_checks = 0;
  int n_fail   = 0;

  tpu_nn_accel dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .ready (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [63:0] x0, input logic [63:0] x1,
                      input logic [63:0] a0, input logic [63:0] a1,
                      input logic [63:0] b0, input logic [63:0] b1);
    dut.datapath.layer1.MM.memory[0] = x0;
    dut.datapath.layer1.MM.memory[1] = x1;
    dut.datapath.layer1.genblk1[0].MM.memory[0] = a0;
    dut.datapath.layer1.genblk1[0].MM.memory[1] = a1;
    dut.datapath.layer1.genblk1[1].MM.memory[0] = b0;
    dut.datapath.layer1.genblk1[1].MM.memory[1] = b1;
  endtask

  // Called at a falling edge while idle; start stays high for `hold` edges.
  // If poke_cyc > 0, neuron0's weights are overwritten at that cycle to show
  // that a held start does not launch a second pass.
  task automatic run_pass(input int hold, input int poke_cyc, output int busy);
    logic done;
    done = 1'b0;
    busy = 0;
    start = 1'b1;
    for (int cyc = 1; cyc < 200 && !done; cyc++) begin
      @(negedge clk);
      if (cyc >= hold) start = 1'b0;
      if (cyc == poke_cyc) begin
        dut.datapath.layer1.genblk1[0].MM.memory[0] = 64'd100;
        dut.datapath.layer1.genblk1[0].MM.memory[1] = 64'd100;
      end
      if (!ready) busy++;
      else done = 1'b1;
    end
    start = 1'b0;
    check("pass_completes", {63'd0, done}, 64'd1);
  endtask

  function automatic logic [63:0] out_of(input int n);
    return (n == 0) ? dut.datapath.layer1.genblk1[0].out : dut.datapath.layer1.genblk1[1].out;
  endfunction

  initial begin
    int busy;
    rst   = 1'b1;
    start = 1'b0;

    // Reset then idle
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_ready", {63'd0, ready}, 64'd1);
    end
    check("reset_out0", out_of(0), 64'd0);
    check("reset_out1", out_of(1), 64'd0);

    // Basic pass: 1*1+1*1 = 2, and 0
    load(64'd1, 64'd1, 64'd1, 64'd1, 64'd0, 64'd0);
    run_pass(2, 0, busy);
    check("basic_busy", 64'(busy), 64'd4);
    check("basic_out0", out_of(0), 64'd2);
    check("basic_out1", out_of(1), 64'd0);
    check("basic_ready", {63'd0, ready}, 64'd1);

    // Signed / ReLU: 3*2 + (-5)*1 = 1 ; 3*1 + (-5)*1 = -2 -> 0
    load(64'd3, -64'sd5, 64'd2, 64'd1, 64'd1, 64'd1);
    run_pass(1, 0, busy);
    check("signed_busy", 64'(busy), 64'd4);
    check("signed_out0", out_of(0), 64'd1);
    check("relu_out1", out_of(1), 64'd0);

    // Held start: one pass, then HOLD until start drops after 20 edges
    load(64'd1, 64'd1, 64'd1, 64'd1, 64'd0, 64'd0);
    run_pass(20, 10, busy);
    check("held_busy", 64'(busy), 64'd20);
    check("held_out0", out_of(0), 64'd2);
    check("held_out1", out_of(1), 64'd0);
    repeat (3) @(negedge clk);
    check("held_idle_ready", {63'd0, ready}, 64'd1);
    check("held_no_retrigger", out_of(0), 64'd2);

    // Reset in the middle of MAC
    start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("midpass_in_mac", 64'(dut.datapath.state), 64'd2);
    rst = 1'b1;
    #1;
    check("midpass_ready", {63'd0, ready}, 64'd1);
    check("midpass_out0", out_of(0), 64'd0);
    check("midpass_state", 64'(dut.datapath.state), 64'd0);
    check("midpass_mem_kept", dut.datapath.layer1.MM.memory[0], 64'd1);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    load(64'd1, 64'd1, 64'd1, 64'd1, 64'd0, 64'd0);
    run_pass(2, 0, busy);
    check("after_reset_busy", 64'(busy), 64'd4);
    check("after_reset_out0", out_of(0), 64'd2);

    // Wrap-around: 2^62*4 truncates to 0; 2^62+2^62 = 2^63 is negative -> 0
    load(64'h4000_0000_0000_0000, 64'h4000_0000_0000_0000, 64'd4, 64'd0, 64'd1, 64'd1);
    for (int r = 0; r < 2; r++) begin
      run_pass(1, 0, busy);
      check("wrap_busy", 64'(busy), 64'd4);
      check("wrap_out0", out_of(0), 64'd0);
      check("wrap_out1", out_of(1), 64'd0);
    end

    // Largest positive accumulator survives ReLU: (2^62-1)*1 + 2^62*1 = 2^63-1
    load(64'h3FFF_FFFF_FFFF_FFFF, 64'h4000_0000_0000_0000, 64'd1, 64'd1, -64'sd1, 64'd0);
    run_pass(1, 0, busy);
    check("max_pos_out0", out_of(0), 64'h7FFF_FFFF_FFFF_FFFF);
    check("neg_prod_out1", out_of(1), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
